// File: rtl/axi_reg_slice.sv
// axi_reg_slice: five independent AXI channel slices (bypass, forward or skid buffer)

// axi_reg_slice_chan: one valid/ready channel stage, payload packed into a flat vector
module axi_reg_slice_chan #(
  parameter int W    = 8,
  parameter int MODE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  generate
    if (MODE == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = i_clk ^ i_rst_n;
      assign o_valid  = i_valid;
      assign o_ready  = i_ready;
      assign o_data   = i_data;
    end else if (MODE == 2) begin : g_fwd
      logic         r_valid;
      logic [W-1:0] r_data;
      assign o_ready = ~r_valid | i_ready;
      assign o_valid = r_valid;
      assign o_data  = r_data;
      // valid flag reloads whenever the stage is empty or being drained
      always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_valid <= 1'b0;
        else if (o_ready) r_valid <= i_valid;
      // payload captured on accepted beats only; not reset
      always_ff @(posedge i_clk)
        if (o_ready && i_valid) r_data <= i_data;
    end else begin : g_full
      localparam logic [1:0] EMPTY = 2'd0;
      localparam logic [1:0] ONE   = 2'd1;
      localparam logic [1:0] TWO   = 2'd2;
      logic [1:0]   r_state, w_next;
      logic         r_ready, r_valid, w_push, w_pop;
      logic [W-1:0] r_data, r_skid;
      assign w_push  = i_valid & r_ready;
      assign w_pop   = r_valid & i_ready;
      assign o_ready = r_ready;
      assign o_valid = r_valid;
      assign o_data  = r_data;
      // occupancy transitions; TWO cannot push because ready is low there
      always_comb
        w_next = (r_state == EMPTY) ? (w_push ? ONE : EMPTY) :
                 (r_state == ONE)   ? ((w_push && !w_pop) ? TWO : (!w_push && w_pop) ? EMPTY : ONE) :
                 (w_pop ? ONE : TWO);
      // state plus registered ready/valid so neither handshake path is combinational
      always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
          r_state <= EMPTY;
          r_ready <= 1'b0;
          r_valid <= 1'b0;
        end else begin
          r_state <= w_next;
          r_ready <= (w_next != TWO);
          r_valid <= (w_next != EMPTY);
        end
      // main register takes the skid entry first, else the incoming beat; skid catches overflow
      always_ff @(posedge i_clk) begin
        if (r_state == TWO && w_pop) r_data <= r_skid;
        else if (w_push && (r_state == EMPTY || w_pop)) r_data <= i_data;
        if (w_push && r_state == ONE && !w_pop) r_skid <= i_data;
      end
    end
  endgenerate
endmodule

module axi_reg_slice #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int AW_MODE    = 1,
  parameter int W_MODE     = 1,
  parameter int B_MODE     = 1,
  parameter int AR_MODE    = 1,
  parameter int R_MODE     = 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     S_AWID,
  input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
  input  logic [7:0]              S_AWLEN,
  input  logic [2:0]              S_AWSIZE,
  input  logic [1:0]              S_AWBURST,
  input  logic [2:0]              S_AWPROT,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  output logic [ID_WIDTH-1:0]     M_AWID,
  output logic [ADDR_WIDTH-1:0]   M_AWADDR,
  output logic [7:0]              M_AWLEN,
  output logic [2:0]              M_AWSIZE,
  output logic [1:0]              M_AWBURST,
  output logic [2:0]              M_AWPROT,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  input  logic [ID_WIDTH-1:0]     S_WID,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WLAST,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [ID_WIDTH-1:0]     M_WID,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WLAST,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [ID_WIDTH-1:0]     M_BID,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ID_WIDTH-1:0]     S_BID,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ID_WIDTH-1:0]     S_ARID,
  input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
  input  logic [7:0]              S_ARLEN,
  input  logic [2:0]              S_ARSIZE,
  input  logic [1:0]              S_ARBURST,
  input  logic [2:0]              S_ARPROT,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [ID_WIDTH-1:0]     M_ARID,
  output logic [ADDR_WIDTH-1:0]   M_ARADDR,
  output logic [7:0]              M_ARLEN,
  output logic [2:0]              M_ARSIZE,
  output logic [1:0]              M_ARBURST,
  output logic [2:0]              M_ARPROT,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [ID_WIDTH-1:0]     M_RID,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RLAST,
  input  logic                    M_RVALID,
  output logic                    M_RREADY,
  output logic [ID_WIDTH-1:0]     S_RID,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RLAST,
  output logic                    S_RVALID,
  input  logic                    S_RREADY
);
  localparam int AXW = ID_WIDTH + ADDR_WIDTH + 16;
  localparam int WW  = ID_WIDTH + DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int BW  = ID_WIDTH + 2;
  localparam int RW  = ID_WIDTH + DATA_WIDTH + 3;

  logic [AXW-1:0] w_aw_m, w_ar_m;
  logic [WW-1:0]  w_w_m;
  logic [BW-1:0]  w_b_s;
  logic [RW-1:0]  w_r_s;

  assign {M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWPROT} = w_aw_m;
  assign {M_WID, M_WDATA, M_WSTRB, M_WLAST}                         = w_w_m;
  assign {S_BID, S_BRESP}                                           = w_b_s;
  assign {M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARPROT} = w_ar_m;
  assign {S_RID, S_RDATA, S_RRESP, S_RLAST}                         = w_r_s;

  axi_reg_slice_chan #(.W(AXW), .MODE(AW_MODE)) u_aw (
    .i_clk(ACLK), .i_rst_n(ARESETn),
    .i_valid(S_AWVALID), .o_ready(S_AWREADY),
    .i_data({S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWPROT}),
    .o_valid(M_AWVALID), .i_ready(M_AWREADY), .o_data(w_aw_m)
  );

  axi_reg_slice_chan #(.W(WW), .MODE(W_MODE)) u_w (
    .i_clk(ACLK), .i_rst_n(ARESETn),
    .i_valid(S_WVALID), .o_ready(S_WREADY),
    .i_data({S_WID, S_WDATA, S_WSTRB, S_WLAST}),
    .o_valid(M_WVALID), .i_ready(M_WREADY), .o_data(w_w_m)
  );

  axi_reg_slice_chan #(.W(BW), .MODE(B_MODE)) u_b (
    .i_clk(ACLK), .i_rst_n(ARESETn),
    .i_valid(M_BVALID), .o_ready(M_BREADY),
    .i_data({M_BID, M_BRESP}),
    .o_valid(S_BVALID), .i_ready(S_BREADY), .o_data(w_b_s)
  );

  axi_reg_slice_chan #(.W(AXW), .MODE(AR_MODE)) u_ar (
    .i_clk(ACLK), .i_rst_n(ARESETn),
    .i_valid(S_ARVALID), .o_ready(S_ARREADY),
    .i_data({S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARPROT}),
    .o_valid(M_ARVALID), .i_ready(M_ARREADY), .o_data(w_ar_m)
  );

  axi_reg_slice_chan #(.W(RW), .MODE(R_MODE)) u_r (
    .i_clk(ACLK), .i_rst_n(ARESETn),
    .i_valid(M_RVALID), .o_ready(M_RREADY),
    .i_data({M_RID, M_RDATA, M_RRESP, M_RLAST}),
    .o_valid(S_RVALID), .i_ready(S_RREADY), .o_data(w_r_s)
  );
endmodule

// File: tb/tb_axi_reg_slice.sv
// tb_axi_reg_slice: directed and randomised checks of axi_reg_slice against per-channel FIFO model
module tb_axi_reg_slice;
  localparam int IDW = 6;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int AWM = 1;
  localparam int WM  = 1;
  localparam int BM  = 0;
  localparam int ARM = 2;
  localparam int RM  = 2;

  logic ACLK, ARESETn;
  logic [IDW-1:0] S_AWID, M_AWID, S_WID, M_WID, M_BID, S_BID, S_ARID, M_ARID, M_RID, S_RID;
  logic [AW-1:0]  S_AWADDR, M_AWADDR, S_ARADDR, M_ARADDR;
  logic [7:0]     S_AWLEN, M_AWLEN, S_ARLEN, M_ARLEN;
  logic [2:0]     S_AWSIZE, M_AWSIZE, S_ARSIZE, M_ARSIZE, S_AWPROT, M_AWPROT, S_ARPROT, M_ARPROT;
  logic [1:0]     S_AWBURST, M_AWBURST, S_ARBURST, M_ARBURST, M_BRESP, S_BRESP, M_RRESP, S_RRESP;
  logic [DW-1:0]  S_WDATA, M_WDATA, M_RDATA, S_RDATA;
  logic [DW/8-1:0] S_WSTRB, M_WSTRB;
  logic S_WLAST, M_WLAST, M_RLAST, S_RLAST;
  logic S_AWVALID, S_AWREADY, M_AWVALID, M_AWREADY;
  logic S_WVALID, S_WREADY, M_WVALID, M_WREADY;
  logic M_BVALID, M_BREADY, S_BVALID, S_BREADY;
  logic S_ARVALID, S_ARREADY, M_ARVALID, M_ARREADY;
  logic M_RVALID, M_RREADY, S_RVALID, S_RREADY;

  axi_reg_slice #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .AW_MODE(AWM), .W_MODE(WM), .B_MODE(BM), .AR_MODE(ARM), .R_MODE(RM)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE),
    .S_AWBURST(S_AWBURST), .S_AWPROT(S_AWPROT), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
    .M_AWBURST(M_AWBURST), .M_AWPROT(M_AWPROT), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .S_WID(S_WID), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .M_WID(M_WID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARBURST(S_ARBURST), .S_ARPROT(S_ARPROT), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
    .M_ARBURST(M_ARBURST), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  logic [127:0] q [5][$];
  logic [127:0] pd [5];
  logic push [5], pop [5], acc [5], rdy_s [5];
  logic up = 1'b0;
  logic [DW-1:0] wout [$];
  logic wlst [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // model: each channel is an in-order FIFO; bypass means wires, forward holds <=1, skid holds <=2
  task automatic chk_chan(input int c, input int md, input string nm,
                          input logic sv, input logic sr, input logic [127:0] sd,
                          input logic mv, input logic mr, input logic [127:0] mdat);
    push[c] = 1'b0;
    pop[c]  = 1'b0;
    if (md == 0) begin
      chk({nm, "_valid"}, 128'(mv), 128'(sv));
      chk({nm, "_ready"}, 128'(sr), 128'(mr));
      chk({nm, "_data"}, mdat, sd);
    end else begin
      chk({nm, "_valid"}, 128'(mv), 128'(q[c].size() != 0));
      if (q[c].size() != 0) chk({nm, "_data"}, mdat, q[c][0]);
      chk({nm, "_ready"}, 128'(sr),
          128'(md == 1 ? (up && q[c].size() < 2) : (q[c].size() == 0 || mr)));
      pop[c]  = mv && mr;
      push[c] = sv && sr;
      pd[c]   = sd;
    end
    acc[c]   = sv && sr;
    rdy_s[c] = sr;
  endtask

  task automatic tick();
    logic rs;
    #1;
    chk_chan(0, AWM, "aw", S_AWVALID, S_AWREADY,
             128'({S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWPROT}),
             M_AWVALID, M_AWREADY,
             128'({M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWPROT}));
    chk_chan(1, WM, "w", S_WVALID, S_WREADY, 128'({S_WID, S_WDATA, S_WSTRB, S_WLAST}),
             M_WVALID, M_WREADY, 128'({M_WID, M_WDATA, M_WSTRB, M_WLAST}));
    chk_chan(2, BM, "b", M_BVALID, M_BREADY, 128'({M_BID, M_BRESP}),
             S_BVALID, S_BREADY, 128'({S_BID, S_BRESP}));
    chk_chan(3, ARM, "ar", S_ARVALID, S_ARREADY,
             128'({S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARPROT}),
             M_ARVALID, M_ARREADY,
             128'({M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARPROT}));
    chk_chan(4, RM, "r", M_RVALID, M_RREADY, 128'({M_RID, M_RDATA, M_RRESP, M_RLAST}),
             S_RVALID, S_RREADY, 128'({S_RID, S_RDATA, S_RRESP, S_RLAST}));
    if (pop[1]) begin
      wout.push_back(M_WDATA);
      wlst.push_back(M_WLAST);
    end
    rs = ARESETn;
    @(posedge ACLK);
    #1;
    for (int c = 0; c < 5; c++) begin
      if (!rs) q[c].delete();
      else begin
        if (pop[c]) void'(q[c].pop_front());
        if (push[c]) q[c].push_back(pd[c]);
      end
    end
    up = rs;
  endtask

  // sources hold VALID and payload until accepted; readies are free-running
  task automatic drive_random();
    if (!S_AWVALID || acc[0]) begin
      S_AWVALID = 1'($urandom_range(0, 1)); S_AWID = IDW'($urandom); S_AWADDR = $urandom;
      S_AWLEN = 8'($urandom); S_AWSIZE = 3'($urandom); S_AWBURST = 2'($urandom); S_AWPROT = 3'($urandom);
    end
    if (!S_WVALID || acc[1]) begin
      S_WVALID = 1'($urandom_range(0, 1)); S_WID = IDW'($urandom); S_WDATA = {$urandom, $urandom};
      S_WSTRB = 8'($urandom); S_WLAST = 1'($urandom);
    end
    if (!M_BVALID || acc[2]) begin
      M_BVALID = 1'($urandom_range(0, 1)); M_BID = IDW'($urandom); M_BRESP = 2'($urandom);
    end
    if (!S_ARVALID || acc[3]) begin
      S_ARVALID = 1'($urandom_range(0, 1)); S_ARID = IDW'($urandom); S_ARADDR = $urandom;
      S_ARLEN = 8'($urandom); S_ARSIZE = 3'($urandom); S_ARBURST = 2'($urandom); S_ARPROT = 3'($urandom);
    end
    if (!M_RVALID || acc[4]) begin
      M_RVALID = 1'($urandom_range(0, 1)); M_RID = IDW'($urandom); M_RDATA = {$urandom, $urandom};
      M_RRESP = 2'($urandom); M_RLAST = 1'($urandom);
    end
    M_AWREADY = 1'($urandom_range(0, 1));
    M_WREADY  = 1'($urandom_range(0, 1));
    S_BREADY  = 1'($urandom_range(0, 1));
    M_ARREADY = 1'($urandom_range(0, 1));
    S_RREADY  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int beat;
    int rd;
    logic saw_low;
    for (int c = 0; c < 5; c++) begin
      acc[c] = 1'b0; push[c] = 1'b0; pop[c] = 1'b0; rdy_s[c] = 1'b0; pd[c] = '0;
    end
    ARESETn = 1'b1;
    {S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWPROT, S_AWVALID, M_AWREADY} = '0;
    {S_WID, S_WDATA, S_WSTRB, S_WLAST, S_WVALID, M_WREADY} = '0;
    {M_BID, M_BRESP, M_BVALID, S_BREADY} = '0;
    {S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARPROT, S_ARVALID, M_ARREADY} = '0;
    {M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID, S_RREADY} = '0;
    #1 ARESETn = 1'b0;
    @(posedge ACLK);
    #1;
    tick();
    tick();
    ARESETn = 1'b1;
    tick();
    chk("rst_release_wready", 128'(S_WREADY), 128'(1));
    chk("rst_release_awready", 128'(S_AWREADY), 128'(1));

    // AW skid stage at full rate: each address appears one cycle after acceptance
    M_AWREADY = 1'b1;
    S_AWVALID = 1'b1;
    S_AWADDR  = 32'h100;
    tick();
    chk("aw_lat_100", 128'(M_AWADDR), 128'(32'h100));
    chk("aw_valid_100", 128'(M_AWVALID), 128'(1));
    S_AWADDR = 32'h104;
    tick();
    chk("aw_lat_104", 128'(M_AWADDR), 128'(32'h104));
    chk("aw_ready_hold", 128'(S_AWREADY), 128'(1));
    S_AWADDR = 32'h108;
    tick();
    chk("aw_lat_108", 128'(M_AWADDR), 128'(32'h108));
    S_AWVALID = 1'b0;
    tick();
    chk("aw_idle", 128'(M_AWVALID), 128'(0));

    // W burst with a two-cycle downstream stall
    wout.delete();
    wlst.delete();
    beat = 0;
    saw_low = 1'b0;
    S_WSTRB = 8'hFF;
    S_WID = 6'h2A;
    for (int n = 0; n < 20; n++) begin
      M_WREADY = !(n == 1 || n == 2);
      S_WVALID = (beat < 4);
      S_WDATA  = DW'(8'hA0 + beat);
      S_WLAST  = (beat == 3);
      tick();
      if (!rdy_s[1]) saw_low = 1'b1;
      if (acc[1]) beat++;
    end
    chk("w_beats_sent", 128'(beat), 128'(4));
    chk("w_ready_dropped", 128'(saw_low), 128'(1));
    chk("w_beats_out", 128'(wout.size()), 128'(4));
    for (int i = 0; i < wout.size(); i++) begin
      chk("w_order", 128'(wout[i]), 128'(8'hA0 + i));
      chk("w_last", 128'(wlst[i]), 128'(i == 3));
    end

    // R forward stage: continuous source, toggling sink ready
    rd = 0;
    M_RVALID = 1'b1;
    for (int n = 0; n < 12; n++) begin
      M_RDATA  = DW'(64'hD000 + rd);
      S_RREADY = n[0];
      tick();
      if (acc[4]) rd++;
    end
    M_RVALID = 1'b0;
    S_RREADY = 1'b1;
    tick();
    tick();
    chk("r_drained", 128'(S_RVALID), 128'(0));

    // B bypass: same-cycle wires
    for (int n = 0; n < 4; n++) begin
      M_BID = IDW'($urandom);
      M_BRESP = 2'($urandom);
      M_BVALID = n[0];
      S_BREADY = n[1];
      tick();
    end
    M_BVALID = 1'b0;

    // reset with two beats held in the W skid stage
    M_WREADY = 1'b0;
    S_WVALID = 1'b1;
    S_WDATA = 64'h1111;
    tick();
    S_WDATA = 64'h2222;
    tick();
    chk("w_full_ready", 128'(S_WREADY), 128'(0));
    chk("w_full_valid", 128'(M_WVALID), 128'(1));
    S_WVALID = 1'b0;
    #2 ARESETn = 1'b0;
    #1;
    chk("rst_async_wvalid", 128'(M_WVALID), 128'(0));
    chk("rst_async_wready", 128'(S_WREADY), 128'(0));
    for (int c = 0; c < 5; c++) q[c].delete();
    up = 1'b0;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    M_WREADY = 1'b1;
    tick();
    chk("rst_rec_wready", 128'(S_WREADY), 128'(1));
    chk("rst_no_stale", 128'(M_WVALID), 128'(0));
    tick();

    // randomised traffic on all five channels
    for (int n = 0; n < 600; n++) begin
      drive_random();
      tick();
    end
    S_AWVALID = 1'b0; S_WVALID = 1'b0; M_BVALID = 1'b0; S_ARVALID = 1'b0; M_RVALID = 1'b0;
    M_AWREADY = 1'b1; M_WREADY = 1'b1; S_BREADY = 1'b1; M_ARREADY = 1'b1; S_RREADY = 1'b1;
    for (int n = 0; n < 4; n++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_reg_slice.md
Name: axi_reg_slice

Overview:
- Parametrised AXI register slice between an upstream AXI master port (S_ side) and a downstream AXI slave port (M_ side).
- Each of the five channels (AW, W, B, AR, R) is independently configured as bypass, forward-registered or fully-registered (2-entry skid buffer).
- Inserted on long AXI paths to break timing without losing throughput or reordering beats.
- Carries the same channel signal set as the VIP's AXI interface, with all widths parametrised.

Parameters:
- ID_WIDTH, 4, width of AWID/WID/BID/ARID/RID.
- ADDR_WIDTH, 32, width of AWADDR/ARADDR.
- DATA_WIDTH, 32, width of WDATA/RDATA; must be a multiple of 8, minimum 8; WSTRB is DATA_WIDTH/8.
- AW_MODE, 1, AW channel mode: 0 bypass, 1 full, 2 forward.
- W_MODE, 1, W channel mode (same encoding).
- B_MODE, 1, B channel mode (same encoding).
- AR_MODE, 1, AR channel mode (same encoding).
- R_MODE, 1, R channel mode (same encoding).

Ports:
- ACLK  input  1  clock; all logic rising-edge.
- ARESETn  input  1  asynchronous active-low reset.
- S_AWID,S_AWADDR,S_AWLEN,S_AWSIZE,S_AWBURST,S_AWPROT  input  ID_WIDTH,ADDR_WIDTH,8,3,2,3  upstream AW payload.
- S_AWVALID  input  1 / S_AWREADY  output  1  upstream AW handshake.
- M_AWID..M_AWPROT  output  same widths  downstream AW payload.
- M_AWVALID  output  1 / M_AWREADY  input  1  downstream AW handshake.
- S_WID,S_WDATA,S_WSTRB,S_WLAST  input  ID_WIDTH,DATA_WIDTH,DATA_WIDTH/8,1  upstream W payload.
- S_WVALID  input  1 / S_WREADY  output  1  upstream W handshake.
- M_WID..M_WLAST  output  same widths  downstream W payload.
- M_WVALID  output  1 / M_WREADY  input  1  downstream W handshake.
- M_BID,M_BRESP  input  ID_WIDTH,2  downstream B payload.
- M_BVALID  input  1 / M_BREADY  output  1  downstream B handshake.
- S_BID,S_BRESP  output  ID_WIDTH,2  upstream B payload.
- S_BVALID  output  1 / S_BREADY  input  1  upstream B handshake.
- S_ARID..S_ARPROT  input  as AW  upstream AR payload.
- S_ARVALID  input  1 / S_ARREADY  output  1  upstream AR handshake.
- M_ARID..M_ARPROT  output  as AW  downstream AR payload.
- M_ARVALID  output  1 / M_ARREADY  input  1  downstream AR handshake.
- M_RID,M_RDATA,M_RRESP,M_RLAST  input  ID_WIDTH,DATA_WIDTH,2,1  downstream R payload.
- M_RVALID  input  1 / M_RREADY  output  1  downstream R handshake.
- S_RID..S_RLAST  output  same widths  upstream R payload.
- S_RVALID  output  1 / S_RREADY  input  1  upstream R handshake.

Behaviour:
- Generic channel slice: source side (VALID in, READY out) feeds sink side (VALID out, READY in). AW/W/AR flow S_→M_; B/R flow M_→S_.
- Transfer on either side occurs when VALID and READY are both high at a rising edge.
- Mode 0, bypass:
  - Pure wires, zero latency, no state.
  - Reset has no effect on this channel.
- Mode 2, forward:
  - One payload register plus a valid flag; sink VALID equals the flag.
  - Source READY = ~flag | sink READY (combinational backward path).
  - Latency 1 cycle; sustains 1 beat/cycle.
- Mode 1, full (skid):
  - States EMPTY, ONE, TWO (main register plus skid register).
  - Both sink VALID and source READY are registered; source READY = (state != TWO).
  - EMPTY + push → ONE.
  - ONE + push and pop → ONE.
  - ONE + push, no pop → TWO.
  - ONE + pop, no push → EMPTY.
  - TWO + pop → ONE; skid entry moves to main.
  - TWO never pushes, because READY is low.
  - Latency 1 cycle; sustains 1 beat/cycle; no bubble when sink READY toggles.
- Ordering and integrity:
  - Beats exit in arrival order.
  - No beat is dropped or duplicated.
  - Payload fields, including LAST and STRB, travel atomically with their beat.
- AXI stability: while sink VALID is high and sink READY is low, sink VALID and payload are held unchanged.
- Reset (asynchronous, ARESETn low), modes 1/2:
  - Sink VALID → 0 immediately; stored beats are discarded.
  - Source READY → 0 in mode 1.
  - Payload registers are not reset.
- Reset release, mode 1: source READY rises at the first ACLK edge after ARESETn is sampled high.
- Reset mid-burst: beats in flight are lost; recovery is the system's responsibility.
- Independence: channels share no state; a stall on one channel never blocks another.

Test Plan:
- AW_MODE=1, M_AWREADY=1, push AWADDR 0x100/0x104/0x108 on consecutive cycles → each appears on M_AW* exactly one cycle later; S_AWREADY stays 1.
- W_MODE=1, 4-beat burst WDATA 0xA0..0xA3, M_WREADY low on cycles 2-3 → S_WREADY drops when 2 beats are held; output order is A0,A1,A2,A3; WLAST only on A3; payload stable during the stall.
- R_MODE=2, M_RVALID continuous, S_RREADY toggling 1/0 → M_RREADY equals ~S_RVALID | S_RREADY each cycle; no RDATA is lost.
- B_MODE=0 → S_BID/S_BRESP/S_BVALID equal M_B* in the same cycle; M_BREADY equals S_BREADY.
- Mode 1 channel holding 2 beats, assert ARESETn low mid-cycle → M_xVALID is 0 before the next ACLK edge; after release S_xREADY returns to 1 within 1 cycle; no stale beat is emitted.
- Randomised VALID/READY on all five channels with DATA_WIDTH=64, ID_WIDTH=6, mixed modes → scoreboard shows in-order, lossless transfer on every channel.
